// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef logic [7:0] byte_t;

  typedef enum logic {IDLE, COLLECT} packer_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO
// Full/empty come from the occupancy count; pointers wrap modulo DEPTH.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// rtl/uart_rx_word_packer.sv - packs UART bytes into little-endian words
// Partial words are dropped after an inter-byte gap of CLKS_PER_BIT*TIMEOUT_BITS cycles.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_dv,
  input  byte_t                         rx_byte,
  output logic [8*BYTES_PER_WORD-1:0]   word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          frame_abort
);

  localparam int WW = 8 * BYTES_PER_WORD;
  localparam int T  = CLKS_PER_BIT * TIMEOUT_BITS;
  localparam int TW = $clog2(T + 1);
  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(T - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);

  packer_state_t  state;
  logic [IW-1:0]  byte_idx;
  logic [IW-1:0]  lane;
  logic [WW-1:0]  shreg;
  logic [WW-1:0]  next_word;
  logic [TW-1:0]  tmo_cnt;
  logic           push_q;
  logic [WW-1:0]  push_word;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  // Merge the incoming byte into its lane; a fresh word starts from zero.
  always_comb begin
    lane      = (state == IDLE) ? '0 : byte_idx;
    next_word = (state == IDLE) ? '0 : shreg;
    next_word[int'(lane)*8 +: 8] = rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= '0;
      shreg       <= '0;
      tmo_cnt     <= '0;
      push_q      <= 1'b0;
      push_word   <= '0;
      frame_abort <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_dv) begin
            shreg <= next_word;
            if (BYTES_PER_WORD == 1) begin
              push_word <= next_word;
              push_q    <= 1'b1;
            end else begin
              byte_idx <= IW'(1);
              tmo_cnt  <= TMO_LOAD;
              state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          // A byte arriving in the expiry cycle wins over the timeout.
          if (rx_dv) begin
            shreg <= next_word;
            if (byte_idx == LAST_IDX) begin
              push_word <= next_word;
              push_q    <= 1'b1;
              byte_idx  <= '0;
              state     <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              tmo_cnt  <= TMO_LOAD;
            end
          end else if (tmo_cnt == '0) begin
            frame_abort <= 1'b1;
            shreg       <= '0;
            byte_idx    <= '0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word_valid = !fifo_empty;
  assign pop        = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (rst)                          overflow <= 1'b0;
    else if (push_q && fifo_full && !pop) overflow <= 1'b1;
    else if (overflow_clr)            overflow <= 1'b0;
  end

  sync_fifo_fwft #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (word_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// tb/tb_uart_rx_word_packer.sv - scoreboard bench for uart_rx_word_packer
module tb_uart_rx_word_packer;

  localparam int BPW   = 2;
  localparam int DEPTH = 16;
  localparam int CPB   = 434;
  localparam int TBITS = 20;
  localparam int T     = CPB * TBITS;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        overflow_clr;
  logic        frame_abort;

  uart_rx_word_packer #(
    .BYTES_PER_WORD (BPW),
    .FIFO_DEPTH     (DEPTH),
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_BITS   (TBITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .frame_abort  (frame_abort)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          abort_cnt = 0;
  logic [15:0] sb[$];
  logic [15:0] held = '0;
  bit          held_v = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks head stability.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (frame_abort) abort_cnt++;
      if (held_v && word_valid) check("hold_stable", word_data, held);
      if (word_valid && word_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", word_data);
        end else begin
          check("word", word_data, sb.pop_front());
        end
      end
      held_v = word_valid && !word_ready;
      held   = word_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
    rx_byte = $urandom_range(0, 255);
  endtask

  initial begin
    int ab0;
    logic [31:0] w;
    rst = 1'b1; rx_dv = 1'b0; rx_byte = '0; word_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_abort", frame_abort, 0);
    rst = 1'b0;
    idle(2);

    // 1: two bytes 1000 cycles apart
    send(8'h34);
    idle(1000);
    sb.push_back(16'h1234);
    send(8'h12);
    check("t1_valid_early", word_valid, 0);
    tick();
    check("t1_valid", word_valid, 1);
    check("t1_data", word_data, 16'h1234);
    check("t1_count", fifo_count, 1);
    word_ready = 1'b1;
    idle(3);
    check("t1_drained", fifo_count, 0);

    // 2: 128 back-to-back pairs
    ab0 = abort_cnt;
    for (int k = 0; k < 128; k++) begin
      sb.push_back({8'(k), 8'(k)});
      send(8'(k));
      send(8'(k));
    end
    idle(4);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_overflow", overflow, 0);
    check("t2_no_abort", abort_cnt, ab0);

    // 3: timeout discards lone byte
    ab0 = abort_cnt;
    send(8'hAA);
    idle(T - 1);
    check("t3_abort_early", frame_abort, 0);
    tick();
    check("t3_abort", frame_abort, 1);
    tick();
    check("t3_abort_len", frame_abort, 0);
    idle(4);
    sb.push_back(16'h6655);
    send(8'h55);
    send(8'h66);
    idle(4);
    check("t3_abort_cnt", abort_cnt, ab0 + 1);
    check("t3_sb_empty", sb.size(), 0);

    // 4: byte at counter==0 wins; one cycle later aborts
    ab0 = abort_cnt;
    sb.push_back(16'hC3B4);
    send(8'hB4);
    idle(T - 1);
    send(8'hC3);
    idle(4);
    check("t4_no_abort", abort_cnt, ab0);
    check("t4_sb_empty", sb.size(), 0);
    send(8'h11);
    idle(T);
    sb.push_back(16'h3322);
    send(8'h22);
    send(8'h33);
    idle(4);
    check("t4b_abort", abort_cnt, ab0 + 1);
    check("t4b_sb_empty", sb.size(), 0);

    // 5: overflow with 17 words into 16 slots
    word_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) sb.push_back({8'(8'hA0 + i), 8'(8'h50 + i)});
      send(8'(8'h50 + i));
      send(8'(8'hA0 + i));
    end
    idle(3);
    check("t5_count", fifo_count, DEPTH);
    check("t5_overflow", overflow, 1);
    check("t5_head", word_data, 16'hA050);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t5_clr", overflow, 0);
    word_ready = 1'b1;
    idle(20);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_count_end", fifo_count, 0);

    // 6: reset mid-word
    send(8'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", word_valid, 0);
    check("t6_data", word_data, 0);
    check("t6_count", fifo_count, 0);
    check("t6_overflow", overflow, 0);
    check("t6_abort", frame_abort, 0);
    sb.push_back(16'h0102);
    send(8'h02);
    send(8'h01);
    idle(4);
    check("t6_sb_empty", sb.size(), 0);

    // Random words with random gaps and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      sb.push_back(w[15:0]);
      send(w[7:0]);
      idle($urandom_range(1, 4));
      send(w[15:8]);
      idle($urandom_range(1, 4));
    end
    rand_ready = 1'b0;
    word_ready = 1'b1;
    idle(40);
    check("rand_sb_empty", sb.size(), 0);
    check("rand_overflow", overflow, 0);
    check("rand_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
